// File: rtl/l3_seq_ctrl.sv
`timescale 1ns/1ps
// l3_seq_ctrl -- level-3 frame sequencer.
// Streams 8*N3 samples from a synchronous sample RAM into the level-3
// datapath, waits for the datapath's window-completion flags, latches the
// boundary positions and offers them on a valid/ready result port.
// Optional feature: define L3_TIMEOUT_EN to add a WAIT watchdog that
// reports err=1 with all-ones results after TIMEOUT_CYC cycles.
//
// Result handshake: res_valid rises when a result is latched and stays high,
// with res_q/res_s/err stable, until a cycle in which res_ready=1. That cycle
// is the transfer; done is high exactly then. res_ready while res_valid=0 is
// ignored.
module l3_seq_ctrl #(
   parameter int ADDR_W      = 12,
   parameter int N3          = 100,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic              clk,
   input  logic              nReset,
   input  logic              start,
   input  logic [ADDR_W-1:0] frame_base,
   output logic              busy,
   output logic              done,
   output logic              sample_rd,
   output logic [ADDR_W-1:0] sample_addr,
   input  logic [15:0]       sample_data,
   output logic [15:0]       data_in_o,
   output logic              dp_nReset,
   input  logic [8:0]        count2,
   input  logic              q_begin_flag,
   input  logic              s_end_flag,
   input  logic              cD_min_found,
   input  logic [15:0]       q_begin,
   input  logic [15:0]       s_end,
   output logic [15:0]       res_q,
   output logic [15:0]       res_s,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              err
);

   // Number of sample reads in one frame.
   localparam int NREADS = 8 * N3;
   localparam int RD_W   = $clog2(NREADS + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLR    = 3'd1,
      STREAM = 3'd2,
      WAIT   = 3'd3,
      RESULT = 3'd4
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] base_q;   // frame base latched on accepted start
   logic [RD_W-1:0]   rd_cnt;   // reads issued so far in this frame
   logic              clr_cnt;  // second CLR cycle marker
   logic              flags_ok; // datapath reports a complete window

`ifdef L3_TIMEOUT_EN
   localparam int WT_W = $clog2(TIMEOUT_CYC + 1);
   logic [WT_W-1:0]   wait_cnt; // WAIT cycles elapsed without flags
   logic              err_q;
`endif

   // All three flags must agree, and only once the coefficient counter has
   // reached its final value; stale flags from earlier counts are rejected.
   assign flags_ok = q_begin_flag & s_end_flag & cD_min_found & (count2 == 9'd1);

   // RAM read data passes straight through to the datapath.
   assign data_in_o = sample_data;

   // Transfer indication: high only in the cycle the result is taken.
   assign done = res_valid & res_ready;

`ifdef L3_TIMEOUT_EN
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // Frame sequencer: state, read address generation and result latching.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state       <= IDLE;
         busy        <= 1'b0;
         sample_rd   <= 1'b0;
         sample_addr <= '0;
         dp_nReset   <= 1'b0;
         res_q       <= '0;
         res_s       <= '0;
         res_valid   <= 1'b0;
         base_q      <= '0;
         rd_cnt      <= '0;
         clr_cnt     <= 1'b0;
`ifdef L3_TIMEOUT_EN
         wait_cnt    <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               // A new frame: capture the base and hold the datapath in reset.
               if (start) begin
                  base_q    <= frame_base;
                  rd_cnt    <= '0;
                  clr_cnt   <= 1'b0;
                  dp_nReset <= 1'b0;
                  busy      <= 1'b1;
                  state     <= CLR;
               end
            end

            CLR: begin
               // Two cycles of datapath reset, then the first read goes out.
               if (clr_cnt) begin
                  dp_nReset   <= 1'b1;
                  sample_rd   <= 1'b1;
                  sample_addr <= base_q;
                  rd_cnt      <= RD_W'(1);
                  state       <= STREAM;
               end else begin
                  clr_cnt <= 1'b1;
               end
            end

            STREAM: begin
               // One read per cycle; the address wraps naturally at 2^ADDR_W.
               if (rd_cnt == RD_W'(NREADS)) begin
                  sample_rd <= 1'b0;
`ifdef L3_TIMEOUT_EN
                  wait_cnt  <= '0;
`endif
                  state     <= WAIT;
               end else begin
                  sample_addr <= base_q + ADDR_W'(rd_cnt);
                  rd_cnt      <= rd_cnt + RD_W'(1);
               end
            end

            WAIT: begin
               // Real flags win over a watchdog expiry in the same cycle.
               if (flags_ok) begin
                  res_q     <= q_begin;
                  res_s     <= s_end;
                  res_valid <= 1'b1;
`ifdef L3_TIMEOUT_EN
                  err_q     <= 1'b0;
`endif
                  state     <= RESULT;
               end
`ifdef L3_TIMEOUT_EN
               else if (wait_cnt == WT_W'(TIMEOUT_CYC - 1)) begin
                  res_q     <= 16'hFFFF;
                  res_s     <= 16'hFFFF;
                  res_valid <= 1'b1;
                  err_q     <= 1'b1;
                  state     <= RESULT;
               end else begin
                  wait_cnt <= wait_cnt + WT_W'(1);
               end
`endif
            end

            RESULT: begin
               // Results stay latched after the transfer; only valid/err drop.
               if (res_ready) begin
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
`ifdef L3_TIMEOUT_EN
                  err_q     <= 1'b0;
`endif
                  state     <= IDLE;
               end
            end

            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               sample_rd <= 1'b0;
               res_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_l3_seq_ctrl.sv
`timescale 1ns/1ps
// tb_l3_seq_ctrl -- self-checking bench for l3_seq_ctrl.
// Frames are driven from a vector table, from random parameters, and from
// hand-written reset sequences. Expected read addresses come from a queue
// filled with (base + i) mod 2^ADDR_W.
module tb_l3_seq_ctrl;

   localparam int ADDR_W      = 12;
   localparam int N3          = 100;
   localparam int TIMEOUT_CYC = 16;
   localparam int NREADS      = 8 * N3;
   localparam int AMOD        = 1 << ADDR_W;

   // ---------------- clock / reset / DUT ----------------
   logic              clk = 1'b0;
   logic              nReset = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] frame_base = '0;
   logic              busy, done, sample_rd, dp_nReset, res_valid, err;
   logic [ADDR_W-1:0] sample_addr;
   logic [15:0]       sample_data = '0;
   logic [15:0]       data_in_o, res_q, res_s;
   logic [8:0]        count2 = '0;
   logic              q_begin_flag = 1'b0, s_end_flag = 1'b0, cD_min_found = 1'b0;
   logic [15:0]       q_begin = '0, s_end = '0;
   logic              res_ready = 1'b0;

   always #5 clk = ~clk;

   l3_seq_ctrl #(.ADDR_W(ADDR_W), .N3(N3), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .clk(clk), .nReset(nReset), .start(start), .frame_base(frame_base),
      .busy(busy), .done(done), .sample_rd(sample_rd), .sample_addr(sample_addr),
      .sample_data(sample_data), .data_in_o(data_in_o), .dp_nReset(dp_nReset),
      .count2(count2), .q_begin_flag(q_begin_flag), .s_end_flag(s_end_flag),
      .cD_min_found(cD_min_found), .q_begin(q_begin), .s_end(s_end),
      .res_q(res_q), .res_s(res_s), .res_valid(res_valid), .res_ready(res_ready),
      .err(err)
   );

   // ---------------- scoreboard ----------------
   int                errors = 0;
   int                checks = 0;
   int                done_seen = 0;
   int                done_exp = 0;
   logic [ADDR_W-1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Counts every done pulse, sampled mid-way through the low clock phase.
   always @(negedge clk) begin
      #3;
      if (done === 1'b1) done_seen++;
   end

   // Watchdog against a stuck run.
   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   // ---------------- driver tasks ----------------
   task automatic clear_flags();
      {q_begin_flag, s_end_flag, cD_min_found} = 3'b000;
      count2 = '0;
   endtask

   // Flags that must never be accepted: a missing flag, or count2 != 1.
   task automatic drive_non_accept();
      if ($urandom_range(0, 1) == 1) begin
         {q_begin_flag, s_end_flag, cD_min_found} = 3'b111;
         count2 = ($urandom_range(0, 1) == 1) ? 9'd0 : 9'($urandom_range(2, 511));
      end else begin
         {q_begin_flag, s_end_flag, cD_min_found} = 3'($urandom_range(0, 6));
         count2 = 9'd1;
      end
      q_begin = 16'($urandom);
      s_end   = 16'($urandom);
   endtask

   // Runs one frame starting at a negedge in IDLE, ending at a negedge in IDLE.
   task automatic run_frame(input logic [ADDR_W-1:0] base, input logic [15:0] q,
                            input logic [15:0] s, input int hold, input int guard,
                            input logic [ADDR_W-1:0] exp_last, input bit expect_timeout);
      logic [ADDR_W-1:0] e;
      logic [ADDR_W-1:0] last_addr;
      logic [15:0]       eq, es;
      logic              eerr;
      int                n;
      exp_q.delete();
      for (int i = 0; i < NREADS; i++) exp_q.push_back(ADDR_W'((int'(base) + i) % AMOD));
      last_addr = '0;

      check("idle_busy", busy, 0);
      start = 1'b1;
      frame_base = base;
      @(negedge clk);
      start = 1'b0;
      frame_base = ADDR_W'($urandom);
      check("clr1_dp_nreset", dp_nReset, 0);
      check("clr1_busy", busy, 1);
      check("clr1_rd", sample_rd, 0);
      @(negedge clk);
      check("clr2_dp_nreset", dp_nReset, 0);
      check("clr2_rd", sample_rd, 0);
      @(negedge clk);
      check("stream_dp_nreset", dp_nReset, 1);

      for (int i = 0; i < NREADS; i++) begin
         e = exp_q.pop_front();
         check($sformatf("read%0d_rd", i), sample_rd, 1);
         check($sformatf("read%0d_addr", i), sample_addr, e);
         last_addr = sample_addr;
         sample_data = 16'($urandom);
         #1 check("data_in_o", data_in_o, sample_data);
         // Stray start, flags and ready while streaming must be ignored.
         start = (i == 100);
         frame_base = ~base;
         {q_begin_flag, s_end_flag, cD_min_found} = 3'($urandom);
         count2 = 9'($urandom_range(0, 2));
         res_ready = 1'($urandom);
         @(negedge clk);
      end
      start = 1'b0;
      res_ready = 1'b0;
      check("last_addr", last_addr, exp_last);
      check("wait_rd", sample_rd, 0);
      check("wait_busy", busy, 1);
      check("wait_valid", res_valid, 0);

      if (expect_timeout) begin
         n = 0;
         while (res_valid !== 1'b1 && n < 64) begin
            drive_non_accept();
            n++;
            @(negedge clk);
         end
         check("timeout_wait_cycles", n, TIMEOUT_CYC);
         eq = 16'hFFFF;
         es = 16'hFFFF;
         eerr = 1'b1;
      end else begin
         for (int g = 0; g < guard; g++) begin
            drive_non_accept();
            @(negedge clk);
            check("guard_valid", res_valid, 0);
            check("guard_err", err, 0);
         end
         {q_begin_flag, s_end_flag, cD_min_found} = 3'b111;
         count2 = 9'd1;
         q_begin = q;
         s_end = s;
         @(negedge clk);
         eq = q;
         es = s;
         eerr = 1'b0;
      end
      clear_flags();
      q_begin = 16'($urandom);
      s_end = 16'($urandom);

      for (int h = 0; h < hold; h++) begin
         check("hold_valid", res_valid, 1);
         check("hold_res_q", res_q, eq);
         check("hold_res_s", res_s, es);
         check("hold_err", err, eerr);
         check("hold_done", done, 0);
         start = 1'($urandom);
         @(negedge clk);
         start = 1'b0;
      end
      check("result_valid", res_valid, 1);
      check("result_res_q", res_q, eq);
      check("result_res_s", res_s, es);
      check("result_err", err, eerr);
      res_ready = 1'b1;
      #1 check("handshake_done", done, 1);
      done_exp++;
      @(negedge clk);
      res_ready = 1'b0;
      check("post_valid", res_valid, 0);
      check("post_busy", busy, 0);
      check("post_err", err, 0);
      check("post_dp_nreset", dp_nReset, 1);
      check("post_rd", sample_rd, 0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [ADDR_W-1:0] base;
      logic [15:0]       q;
      logic [15:0]       s;
      int                hold;
      int                guard;
      logic [ADDR_W-1:0] exp_last;
   } vec_t;

   vec_t vecs[4];

   initial begin
      logic [ADDR_W-1:0] b;
      vecs[0] = '{base: 12'h010, q: 16'd37,    s: 16'd52,    hold: 5, guard: 3, exp_last: 12'h32F};
      vecs[1] = '{base: 12'hFF0, q: 16'h1234,  s: 16'h00AB,  hold: 0, guard: 0, exp_last: 12'h30F};
      vecs[2] = '{base: 12'hCE0, q: 16'hFFFF,  s: 16'h0000,  hold: 2, guard: 8, exp_last: 12'hFFF};
      vecs[3] = '{base: 12'hCE1, q: 16'h0001,  s: 16'h0002,  hold: 1, guard: 1, exp_last: 12'h000};

      // Reset held with start high: nothing may leave IDLE.
      nReset = 1'b0;
      start = 1'b1;
      frame_base = 12'h123;
      res_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rd", sample_rd, 0);
      check("rst_addr", sample_addr, 0);
      check("rst_dp_nreset", dp_nReset, 0);
      check("rst_res_q", res_q, 0);
      check("rst_res_s", res_s, 0);
      check("rst_valid", res_valid, 0);
      check("rst_err", err, 0);
      start = 1'b0;
      nReset = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("idle_after_rst_busy", busy, 0);
         check("idle_after_rst_dp_nreset", dp_nReset, 0);
         check("idle_after_rst_valid", res_valid, 0);
      end
      res_ready = 1'b0;

      foreach (vecs[k])
         run_frame(vecs[k].base, vecs[k].q, vecs[k].s, vecs[k].hold, vecs[k].guard,
                   vecs[k].exp_last, 1'b0);

      // Random frames against the address model.
      for (int r = 0; r < 4; r++) begin
         b = ADDR_W'($urandom_range(0, AMOD - 1));
         run_frame(b, 16'($urandom), 16'($urandom), $urandom_range(0, 6),
                   $urandom_range(0, 8), ADDR_W'((int'(b) + NREADS - 1) % AMOD), 1'b0);
      end

`ifdef L3_TIMEOUT_EN
      run_frame(12'h100, 16'h0, 16'h0, 2, 0, 12'h41F, 1'b1);
`else
      // Long wait with no timeout: err must stay low throughout.
      run_frame(12'h100, 16'h0BAD, 16'h0CAB, 1, 40, 12'h41F, 1'b0);
`endif

      // Reset during STREAM abandons the frame immediately.
      start = 1'b1;
      frame_base = 12'h200;
      @(negedge clk);
      start = 1'b0;
      repeat (2 + 50) @(negedge clk);
      check("mid_pre_rd", sample_rd, 1);
      check("mid_pre_addr", sample_addr, 12'h232);
      #2 nReset = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_rd", sample_rd, 0);
      check("mid_rst_dp_nreset", dp_nReset, 0);
      check("mid_rst_addr", sample_addr, 0);
      @(negedge clk);
      nReset = 1'b1;
      @(negedge clk);
      check("mid_after_busy", busy, 0);
      run_frame(12'h7FF, 16'h4321, 16'h8765, 3, 2, 12'hB1E, 1'b0);

      // Reset while a result is pending: result lost, no done pulse.
      start = 1'b1;
      frame_base = 12'h444;
      @(negedge clk);
      start = 1'b0;
      repeat (2 + NREADS) @(negedge clk);
      check("pend_wait_rd", sample_rd, 0);
      check("pend_wait_busy", busy, 1);
      {q_begin_flag, s_end_flag, cD_min_found} = 3'b111;
      count2 = 9'd1;
      q_begin = 16'hAAAA;
      s_end = 16'h5555;
      @(negedge clk);
      clear_flags();
      check("pend_valid", res_valid, 1);
      check("pend_res_q", res_q, 16'hAAAA);
      #2 nReset = 1'b0;
      #1;
      check("pend_rst_valid", res_valid, 0);
      check("pend_rst_done", done, 0);
      check("pend_rst_res_q", res_q, 0);
      check("pend_rst_busy", busy, 0);
      @(negedge clk);
      nReset = 1'b1;
      repeat (2) @(negedge clk);
      check("pend_after_valid", res_valid, 0);

      check("done_pulses", done_seen, done_exp);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/l3_seq_ctrl.md
L3_SEQ_CTRL -- requirements
Module: l3_seq_ctrl

Interface
- REQ-001 SHALL have parameter ADDR_W, default 12: sample memory address width.
- REQ-002 SHALL have parameter N3, default 100: level-3 coefficients per frame; equals the datapath's compile-time n3.
- REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024: WAIT watchdog limit in cycles.
- REQ-004 SHALL have port clk, input, 1: clock; all state on rising edge.
- REQ-005 SHALL have port nReset, input, 1: reset, asynchronous, active-low.
- REQ-006 SHALL have port start, input, 1: single-cycle frame request.
- REQ-007 SHALL have port frame_base, input, ADDR_W: first sample address, sampled on accepted start.
- REQ-008 SHALL have port busy, output, 1: high in every state except IDLE.
- REQ-009 SHALL have port done, output, 1: one-cycle pulse on result handshake.
- REQ-010 SHALL have port sample_rd, output, 1: synchronous sample RAM read enable; data arrives next cycle.
- REQ-011 SHALL have port sample_addr, output, ADDR_W: RAM read address.
- REQ-012 SHALL have port sample_data, input, 16: RAM read data.
- REQ-013 SHALL have port data_in_o, output, 16: datapath data_in, combinationally equal to sample_data.
- REQ-014 SHALL have port dp_nReset, output, 1: registered active-low datapath reset.
- REQ-015 SHALL have port count2, input, 9: datapath coefficient down-counter.
- REQ-016 SHALL have ports q_begin_flag, s_end_flag and cD_min_found, input, 1 each: datapath window-completion flags.
- REQ-017 SHALL have ports q_begin and s_end, input, 16 each: datapath boundary positions.
- REQ-018 SHALL have ports res_q and res_s, output, 16 each: latched results.
- REQ-019 SHALL have port res_valid, output, 1; port res_ready, input, 1: valid/ready result handshake.
- REQ-020 SHALL have port err, output, 1: timeout indication qualified by res_valid.

Function
- REQ-021 SHALL implement states IDLE, CLR, STREAM, WAIT, RESULT.
- REQ-022 IDLE: start=1 SHALL latch frame_base, clear the read counter and enter CLR; start in any other state SHALL be ignored.
- REQ-023 CLR SHALL hold dp_nReset=0 for exactly 2 cycles, then drive dp_nReset=1 and enter STREAM.
- REQ-024 STREAM SHALL assert sample_rd every cycle with sample_addr = base + read count, modulo 2^ADDR_W (wrap permitted).
- REQ-025 STREAM SHALL issue exactly 8*N3 reads, then enter WAIT with sample_rd=0.
- REQ-026 WAIT SHALL remain until q_begin_flag, s_end_flag and cD_min_found are all 1 in the same cycle, then register res_q=q_begin and res_s=s_end and enter RESULT.
- REQ-027 RESULT SHALL hold res_valid=1 with stable res_q, res_s and err until res_ready=1; that cycle SHALL pulse done, and the next state SHALL be IDLE with res_valid=0.
- REQ-028 res_ready while res_valid=0 SHALL have no effect.
- REQ-029 dp_nReset SHALL remain 1 after the frame so that datapath outputs persist until the next start.
- REQ-030 count2 SHALL be used only as a guard: WAIT SHALL NOT accept flags while count2 != 1.

Reset
- REQ-031 nReset=0 SHALL asynchronously force state IDLE, busy=0, done=0, sample_rd=0, sample_addr=0, dp_nReset=0, res_q=0, res_s=0, res_valid=0, err=0, counters 0.
- REQ-032 Reset asserted mid-frame SHALL abandon the frame; a pending result SHALL be lost, with no done pulse.

Configuration
- REQ-033 With L3_TIMEOUT_EN defined, a WAIT cycle counter SHALL, on reaching TIMEOUT_CYC without flags, force RESULT with err=1 and res_q=res_s=16'hFFFF.
- REQ-034 Without L3_TIMEOUT_EN, WAIT SHALL wait indefinitely and err SHALL be constant 0.

Verification
- REQ-035 SHALL verify: reset then idle -> busy=0, dp_nReset=0, res_valid=0, and start ignored while nReset=0.
- REQ-036 SHALL verify: start, frame_base=0x010 -> 2 CLR cycles, 800 reads at addresses 0x010..0x32F, then WAIT.
- REQ-037 SHALL verify: frame_base=0xFF0, ADDR_W=12 -> address wraps 0xFFF to 0x000 with no gap.
- REQ-038 SHALL verify: flags rise with q_begin=37, s_end=52 and res_ready held low for 5 cycles -> res_valid stable 5 cycles, res_q=37, res_s=52, one done pulse on release.
- REQ-039 SHALL verify: with L3_TIMEOUT_EN, TIMEOUT_CYC=16 and flags never set -> res_valid after 16 WAIT cycles with err=1 and res_q=0xFFFF.
- REQ-040 SHALL verify: nReset pulsed during STREAM -> immediate IDLE, sample_rd=0, and a new start runs a full frame.
